// File: rtl/timer_bank_pkg.sv
// Shared register map, control layout and status bit positions for the MMIO timer bank.
package timer_bank_pkg;

  localparam int BUS_W = 32;

  // {global, offset[2:0]}: channel registers live below 8, global ones at 8 and up
  typedef enum logic [3:0] {
    REG_CTRL     = 4'h0,
    REG_RELOAD   = 4'h1,
    REG_COUNT    = 4'h2,
    REG_STATUS   = 4'h3,
    REG_CAPTURE  = 4'h4,
    REG_PRESCALE = 4'h8,
    REG_PENDING  = 4'h9
  } reg_off_e;

  typedef struct packed {
    logic irq_en;
    logic auto_rl;
    logic en;
  } ctrl_t;

  localparam int STAT_EXP = 0;
  localparam int STAT_CAP = 1;

  function automatic logic [3:0] reg_key(input logic is_global, input logic [2:0] off);
    return {is_global, off};
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One prescaled down-counter channel: CTRL/RELOAD/COUNT/STATUS and, with TIMER_CAPTURE_EN,
// a synchronised capture input feeding CAPTURE and STATUS.cap.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             wr_ctrl,
  input  logic             wr_reload,
  input  logic             wr_count,
  input  logic             wr_status,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cap_in,
  output logic [2:0]       ctrl,
  output logic [WIDTH-1:0] reload,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       status,
  output logic [WIDTH-1:0] capture,
  output logic             irq_req
);

  ctrl_t            ctrl_r;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] reload_r;
  logic             exp_r;
  logic             expire;

  assign expire = tick & ctrl_r.en & (count_r == '0);

  // Bus writes take priority over tick-driven updates; expiry beats a W1C of exp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r   <= '0;
      count_r  <= '0;
      reload_r <= '0;
      exp_r    <= 1'b0;
    end else begin
      if (wr_ctrl)
        ctrl_r <= ctrl_t'(wdata[2:0]);
      else if (expire && !ctrl_r.auto_rl)
        ctrl_r.en <= 1'b0;

      if (wr_reload)
        reload_r <= wdata;

      if (wr_count)
        count_r <= wdata;
      else if (tick && ctrl_r.en) begin
        if (count_r != '0)
          count_r <= count_r - WIDTH'(1);
        else if (ctrl_r.auto_rl)
          count_r <= reload_r;
      end

      if (expire)
        exp_r <= 1'b1;
      else if (wr_status && wdata[STAT_EXP])
        exp_r <= 1'b0;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [2:0]       sync_r;
  logic             cap_r;
  logic [WIDTH-1:0] capture_r;
  logic             cap_edge;

  // sync_r[1:0] is the synchroniser, sync_r[2] the previous synchronised level
  assign cap_edge = sync_r[1] & ~sync_r[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r    <= '0;
      cap_r     <= 1'b0;
      capture_r <= '0;
    end else begin
      sync_r <= {sync_r[1:0], cap_in};
      if (cap_edge) begin
        capture_r <= count_r;
        cap_r     <= 1'b1;
      end else if (wr_status && wdata[STAT_CAP]) begin
        cap_r <= 1'b0;
      end
    end
  end

  assign capture          = capture_r;
  assign status[STAT_CAP] = cap_r;
`else
  logic unused_cap_in;
  assign unused_cap_in    = cap_in;
  assign capture          = '0;
  assign status[STAT_CAP] = 1'b0;
`endif

  assign status[STAT_EXP] = exp_r;
  assign ctrl             = ctrl_r;
  assign reload           = reload_r;
  assign count            = count_r;
  assign irq_req          = exp_r & ctrl_r.irq_en;

endmodule

// File: rtl/mmio_timer_bank.sv
// N-channel MMIO timer bank: address decode, global prescaler, registered read port and IRQs.
// Optional capture inputs are enabled by defining TIMER_CAPTURE_EN.
module mmio_timer_bank
  import timer_bank_pkg::*;
#(
  parameter int  NCH   = 4,
  parameter int  WIDTH = 32,
  parameter int  PRE_W = 16,
  localparam int AW    = $clog2(NCH + 1) + 3
) (
  input  logic           clk,
  input  logic           Rst_n,
  input  logic           bus_sel,
  input  logic           bus_wr,
  input  logic [AW-1:0]  bus_addr,
  input  logic [31:0]    bus_wdata,
  output logic [31:0]    bus_rdata,
  output logic           bus_rvalid,
  input  logic [NCH-1:0] cap_in,
  output logic [NCH-1:0] irq_vec,
  output logic           irq
);

  localparam int BW = AW - 3;

  logic [BW-1:0]    blk;
  logic [2:0]       off;
  logic             is_glob;
  logic [3:0]       key;
  logic             wr;
  logic             rd;
  logic             tick;
  logic [PRE_W-1:0] prescale_r;
  logic [PRE_W-1:0] pcnt_r;

  assign blk     = bus_addr[AW-1:3];
  assign off     = bus_addr[2:0];
  assign is_glob = (blk == BW'(NCH));
  assign key     = reg_key(is_glob, off);
  assign wr      = bus_sel & bus_wr;
  assign rd      = bus_sel & ~bus_wr;
  assign tick    = (pcnt_r == prescale_r);

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prescale_r <= '0;
      pcnt_r     <= '0;
    end else if (wr && key == REG_PRESCALE) begin
      prescale_r <= bus_wdata[PRE_W-1:0];
      pcnt_r     <= '0;
    end else begin
      pcnt_r <= tick ? '0 : pcnt_r + PRE_W'(1);
    end
  end

  logic [2:0]       ctrl_a    [NCH];
  logic [WIDTH-1:0] reload_a  [NCH];
  logic [WIDTH-1:0] count_a   [NCH];
  logic [1:0]       status_a  [NCH];
  logic [WIDTH-1:0] capture_a [NCH];
  logic [NCH-1:0]   irq_req;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic sel_ch;
    assign sel_ch = wr & (blk == BW'(i));

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .rst_n     (Rst_n),
      .tick      (tick),
      .wr_ctrl   (sel_ch && key == REG_CTRL),
      .wr_reload (sel_ch && key == REG_RELOAD),
      .wr_count  (sel_ch && key == REG_COUNT),
      .wr_status (sel_ch && key == REG_STATUS),
      .wdata     (bus_wdata[WIDTH-1:0]),
      .cap_in    (cap_in[i]),
      .ctrl      (ctrl_a[i]),
      .reload    (reload_a[i]),
      .count     (count_a[i]),
      .status    (status_a[i]),
      .capture   (capture_a[i]),
      .irq_req   (irq_req[i])
    );
  end

  logic [BUS_W-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NCH; i++) begin
      if (blk == BW'(i)) begin
        case (key)
          REG_CTRL:    rd_mux = 32'(ctrl_a[i]);
          REG_RELOAD:  rd_mux = 32'(reload_a[i]);
          REG_COUNT:   rd_mux = 32'(count_a[i]);
          REG_STATUS:  rd_mux = 32'(status_a[i]);
          REG_CAPTURE: rd_mux = 32'(capture_a[i]);
          default:     ;
        endcase
      end
    end
    case (key)
      REG_PRESCALE: rd_mux = 32'(prescale_r);
      REG_PENDING:  rd_mux = 32'(irq_vec);
      default:      ;
    endcase
  end

  // p1: registered read data and interrupt outputs
  logic [BUS_W-1:0] rdata_p1;
  logic             vld_p1;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
      irq_vec  <= '0;
      irq      <= 1'b0;
    end else begin
      rdata_p1 <= rd ? rd_mux : '0;
      vld_p1   <= rd;
      irq_vec  <= irq_req;
      irq      <= |irq_req;
    end
  end

  assign bus_rdata  = rdata_p1;
  assign bus_rvalid = vld_p1;

endmodule
